// File: rtl/npu_pkg.sv
// Shared NPU definitions: fetch controller state encoding and RAM read latency.
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } fetch_state_t;

  // Read latency of the instruction RAM, address register to q_b.
  localparam int INST_FETCH_RD_LAT = 2;

endpackage

// File: rtl/inst_fetch_obuf.sv
// Small register FIFO holding instructions read back from the RAM until the
// decoder takes them. Reports its occupancy and supports a synchronous flush.
module inst_fetch_obuf #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy update; flush empties the buffer in one cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the consumer only looks at it while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: loads a host program into the instruction RAM,
// then streams it back to the decoder with credit-based read issue so the
// output buffer can never overflow under backpressure.
module inst_fetch_ctrl
  import npu_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 9,
  parameter int DEPTH      = 512,
  parameter int RD_LAT     = INST_FETCH_RD_LAT,
  parameter int OBUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          run_start,
  input  logic          abort,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic          inst_last,
  output logic          busy,
  output logic          done,
  output logic          load_err,
  output logic [AW:0]   prog_len,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data
);

  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam logic [AW:0] ONE_L    = (AW + 1)'(1);
  localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          load_err_q, load_err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_out_q, wr_addr_out_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] rd_addr_out_q, rd_addr_out_d;
  logic [AW:0]   issued_q, issued_d;
  logic          done_q, done_d;

  // Bit 0 is the cycle the address sits in the RAM address register; bit
  // RD_LAT is the cycle its data is on q_b and gets captured.
  logic [RD_LAT:0] vld_q, last_q;

  logic          issue, issue_last, try_issue, flush, credit_ok, pop;
  logic [AW-1:0] base_rd;
  logic [AW:0]   base_iss;
  int            occ;

  logic [DW:0]   head_word;
  logic [CW-1:0] obuf_count;
  logic          head_last;
  logic [DW-1:0] head_data;

  assign {head_last, head_data} = head_word;
  assign inst_valid = (obuf_count != '0);
  assign inst_data  = inst_valid ? head_data : '0;
  assign inst_last  = inst_valid & head_last;
  assign pop        = inst_valid & inst_ready;

  // Reads in flight plus buffered words, net of this cycle's pop, must leave
  // room for one more before another read may be issued.
  always_comb begin
    occ = 0;
    for (int i = 0; i <= RD_LAT; i++) begin
      if (vld_q[i]) occ++;
    end
    occ = occ + int'(obuf_count);
    if (pop) occ--;
    credit_ok = (occ < OBUF_DEPTH);
  end

  // Next-state logic for the phase FSM, host writes and read issue.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    prog_len_d    = prog_len_q;
    load_err_d    = load_err_q;
    wr_en_d       = 1'b0;
    wr_addr_out_d = wr_addr_out_q;
    wr_data_d     = wr_data_q;
    rd_addr_d     = rd_addr_q;
    rd_addr_out_d = rd_addr_out_q;
    issued_d      = issued_q;
    done_d        = 1'b0;
    flush         = 1'b0;
    issue         = 1'b0;
    issue_last    = 1'b0;
    try_issue     = 1'b0;
    base_rd       = rd_addr_q;
    base_iss      = issued_q;
    if (abort) begin
      state_d = IDLE;
      flush   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_d    = LOAD;
            wr_addr_d  = '0;
            prog_len_d = '0;
            load_err_d = 1'b0;
          end else if (run_start && (prog_len_q != '0)) begin
            // The first read goes out on the same edge that enters RUN.
            state_d   = RUN;
            rd_addr_d = '0;
            issued_d  = '0;
            base_rd   = '0;
            base_iss  = '0;
            try_issue = 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            wr_en_d       = 1'b1;
            wr_addr_out_d = wr_addr_q;
            wr_data_d     = load_data;
            wr_addr_d     = wr_addr_q + AW'(1);
            prog_len_d    = prog_len_q + ONE_L;
            if (load_last) begin
              state_d = IDLE;
            end else if (prog_len_q == LAST_IDX) begin
              load_err_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        RUN: begin
          try_issue = (issued_q < prog_len_q);
        end
        DRAIN: begin
          if (pop && head_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (try_issue && credit_ok) begin
        issue         = 1'b1;
        issue_last    = (base_iss == prog_len_q - ONE_L);
        rd_addr_out_d = base_rd;
        rd_addr_d     = base_rd + AW'(1);
        issued_d      = base_iss + ONE_L;
        if (issue_last) state_d = DRAIN;
      end
    end
  end

  // State, counters and registered RAM port signals.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      prog_len_q    <= '0;
      load_err_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_out_q <= '0;
      wr_data_q     <= '0;
      rd_addr_q     <= '0;
      rd_addr_out_q <= '0;
      issued_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      prog_len_q    <= prog_len_d;
      load_err_q    <= load_err_d;
      wr_en_q       <= wr_en_d;
      wr_addr_out_q <= wr_addr_out_d;
      wr_data_q     <= wr_data_d;
      rd_addr_q     <= rd_addr_d;
      rd_addr_out_q <= rd_addr_out_d;
      issued_q      <= issued_d;
      done_q        <= done_d;
    end
  end

  // Read shift pipe tracking which RAM output cycles carry issued data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (flush) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= {vld_q[RD_LAT-1:0], issue};
      last_q <= {last_q[RD_LAT-1:0], issue_last};
    end
  end

  inst_fetch_obuf #(
    .W     (DW + 1),
    .DEPTH (OBUF_DEPTH),
    .CW    (CW)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (vld_q[RD_LAT]),
    .push_data ({last_q[RD_LAT], ram_rd_data}),
    .pop       (pop),
    .head_data (head_word),
    .count     (obuf_count)
  );

  assign load_ready  = (state_q == LOAD) && !abort;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign load_err    = load_err_q;
  assign prog_len    = prog_len_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_out_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = rd_addr_out_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl with a behavioural RAM and an
// output scoreboard filled when each run is started.
module tb_inst_fetch_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int DEPTH = 512;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start, load_valid, load_ready, load_last;
  logic [DW-1:0] load_data;
  logic          run_start, abort;
  logic          inst_valid, inst_ready, inst_last;
  logic [DW-1:0] inst_data;
  logic          busy, done, load_err;
  logic [AW:0]   prog_len;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt = 0;
  int exp_cnt = 0;
  int done_cnt = 0;
  int model_len = 0;

  logic [DW:0]      sb_q [$];
  logic [AW+DW-1:0] wr_log [$];
  logic [DW-1:0]    prog [DEPTH];
  logic             stall_prev = 1'b0;
  logic [DW:0]      held;

  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .run_start   (run_start),
    .abort       (abort),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_last   (inst_last),
    .busy        (busy),
    .done        (done),
    .load_err    (load_err),
    .prog_len    (prog_len),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // Behavioural dual-port RAM with RD_LAT registered read stages.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd_stage [RD_LAT];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    rd_stage[0] <= ram[ram_rd_addr];
    for (int i = 1; i < RD_LAT; i++) rd_stage[i] <= rd_stage[i-1];
  end
  assign ram_rd_data = rd_stage[RD_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard compare, hold-while-stalled, done and write log.
  always @(negedge clk) begin
    logic [DW:0] exp_w;
    if (rst) begin
      if (stall_prev) begin
        check("hold_valid", {63'b0, inst_valid}, 64'd1);
        check("hold_data", {31'b0, inst_last, inst_data}, {31'b0, held});
      end
      if (inst_valid && inst_ready) begin
        acc_cnt++;
        $display("out %0d data=%h last=%0d", acc_cnt, inst_data, inst_last);
        if (sb_q.size() != 0) begin
          exp_w = sb_q.pop_front();
          check("inst", {31'b0, inst_last, inst_data}, {31'b0, exp_w});
        end
      end
      if (done) done_cnt++;
      if (ram_wr_en) wr_log.push_back({ram_wr_addr, ram_wr_data});
    end
    stall_prev = rst && inst_valid && !inst_ready && !abort;
    held = {inst_last, inst_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int n, input logic [DW-1:0] base, input bit with_last);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_ready", {63'b0, load_ready}, 64'd1);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + DW'(i);
      load_last  = with_last && (i == n - 1);
      prog[i]    = load_data;
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    model_len  = n;
    tick();
    tick();
  endtask

  task automatic start_run();
    for (int i = 0; i < model_len; i++) sb_q.push_back({(i == model_len - 1), prog[i]});
    exp_cnt += model_len;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic drain(input int mode, input int budget);
    int cyc = 0;
    while ((busy || sb_q.size() != 0) && cyc < budget) begin
      case (mode)
        0:       inst_ready = 1'b1;
        1:       inst_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: inst_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      cyc++;
    end
    check("drain_busy", {63'b0, busy}, 64'd0);
    inst_ready = 1'b0;
    tick();
    check("out_count", acc_cnt, exp_cnt);
    acc_cnt = 0;
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nv;
    load_start = 0; load_valid = 0; load_data = '0; load_last = 0;
    run_start = 0; abort = 0; inst_ready = 0;
    repeat (3) tick();

    // Reset state
    check("rst_valid", {63'b0, inst_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_prog_len", 64'(prog_len), 64'd0);
    check("rst_load_err", {63'b0, load_err}, 64'd0);
    check("rst_load_ready", {63'b0, load_ready}, 64'd0);
    check("rst_wr_en", {63'b0, ram_wr_en}, 64'd0);
    rst = 1'b1;
    tick();

    // run_start with an empty program is ignored
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("empty_run_busy", {63'b0, busy}, 64'd0);
    tick();
    check("empty_run_valid", {63'b0, inst_valid}, 64'd0);

    // Load 5 words, then run with ready high
    wr_log.delete();
    load_prog(5, 32'hA0, 1'b1);
    check("t1_prog_len", 64'(prog_len), 64'd5);
    check("t1_busy", {63'b0, busy}, 64'd0);
    check("t1_load_err", {63'b0, load_err}, 64'd0);
    check("t1_wr_count", 64'(wr_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
      logic [AW+DW-1:0] ew;
      ew = {AW'(i), 32'hA0 + 32'(i)};
      check("t1_wr", 64'(wr_log[i]), 64'(ew));
    end
    done_cnt = 0;
    inst_ready = 1'b1;
    start_run();
    lat = 0;
    while (!inst_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("t1_latency", lat, 3);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (inst_valid) nv++;
      tick();
    end
    check("t1_throughput", nv, 5);
    drain(0, 50);
    check("t1_done", done_cnt, 1);

    // Same program under a 1,0,0,1 ready pattern
    done_cnt = 0;
    inst_ready = 1'b0;
    start_run();
    drain(1, 200);
    check("t2_done", done_cnt, 1);

    // load_start during RUN is ignored
    done_cnt = 0;
    start_run();
    tick();
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t5_busy", {63'b0, busy}, 64'd1);
    check("t5_load_ready", {63'b0, load_ready}, 64'd0);
    check("t5_prog_len", 64'(prog_len), 64'd5);
    drain(0, 50);
    check("t5_done", done_cnt, 1);

    // Full-depth load without load_last, then random backpressure run
    load_prog(DEPTH, 32'h5000_0000, 1'b0);
    check("t3_load_err", {63'b0, load_err}, 64'd1);
    check("t3_prog_len", 64'(prog_len), 64'd512);
    check("t3_busy", {63'b0, busy}, 64'd0);
    done_cnt = 0;
    start_run();
    drain(2, 4000);
    check("t3_done", done_cnt, 1);

    // Abort on the second output while stalled
    load_prog(5, 32'hA0, 1'b1);
    check("t4_load_err", {63'b0, load_err}, 64'd0);
    done_cnt = 0;
    inst_ready = 1'b0;
    start_run();
    nv = 0;
    while (!inst_valid && nv < 20) begin
      tick();
      nv++;
    end
    check("t4_first_valid", {63'b0, inst_valid}, 64'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("t4_second_valid", {63'b0, inst_valid}, 64'd1);
    check("t4_second_data", 64'(inst_data), 64'h0A1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_valid", {63'b0, inst_valid}, 64'd0);
    check("t4_abort_busy", {63'b0, busy}, 64'd0);
    sb_q.delete();
    acc_cnt = 0;
    exp_cnt = 0;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (inst_valid) nv++;
      tick();
    end
    check("t4_quiet", nv, 0);
    check("t4_no_done", done_cnt, 0);
    check("t4_prog_len", 64'(prog_len), 64'd5);
    inst_ready = 1'b1;
    start_run();
    drain(0, 50);
    check("t4_replay_done", done_cnt, 1);

    // Reset mid-RUN
    inst_ready = 1'b0;
    start_run();
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    check("t6_valid", {63'b0, inst_valid}, 64'd0);
    check("t6_busy", {63'b0, busy}, 64'd0);
    check("t6_prog_len", 64'(prog_len), 64'd0);
    check("t6_rd_addr", 64'(ram_rd_addr), 64'd0);
    check("t6_data", 64'(inst_data), 64'd0);
    tick();
    rst = 1'b1;
    sb_q.delete();
    acc_cnt = 0;
    exp_cnt = 0;
    tick();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    repeat (5) tick();
    check("t6_run_ignored_busy", {63'b0, busy}, 64'd0);
    check("t6_run_ignored_valid", {63'b0, inst_valid}, 64'd0);
    load_prog(3, 32'hC0, 1'b1);
    check("t6_prog_len_new", 64'(prog_len), 64'd3);
    done_cnt = 0;
    inst_ready = 1'b1;
    start_run();
    drain(0, 50);
    check("t6_done", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
